// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter: valid/ready flow-control wrapper around a flag-less
// synchronous FIFO with 1-cycle registered read latency. Tracks FIFO
// occupancy, issues safe write/read strobes and hides the read latency
// behind a 2-entry ordered output buffer.
//
// Optional build macro: FIFO_ADAPT_STATS_EN adds peak_level and stall_cnt.
module fifo_stream_adapter #(
    parameter int DATA_LEN   = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 sys_rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_LEN-1:0]  in_data,
    output logic                 fifo_wr_en,
    output logic [DATA_LEN-1:0]  fifo_wr_data,
    output logic                 fifo_rd_en,
    input  logic [DATA_LEN-1:0]  fifo_rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_LEN-1:0]  out_data,
`ifdef FIFO_ADAPT_STATS_EN
    output logic [CNT_WIDTH-1:0] peak_level,
    output logic [15:0]          stall_cnt,
`endif
    output logic [CNT_WIDTH-1:0] level
);

    localparam logic [CNT_WIDTH-1:0] FULL_LEVEL = CNT_WIDTH'(DEPTH);

    logic                rd_pend;     // a read was issued last cycle; data arrives now
    logic [1:0]          buf_cnt;     // output buffer occupancy, 0..2
    logic [DATA_LEN-1:0] buf_head;    // oldest buffered word (0 when empty)
    logic [DATA_LEN-1:0] buf_tail;    // second word (0 unless buf_cnt == 2)

    logic                pop;
    logic [1:0]          committed;   // buffer slots spoken for after this cycle's pop
    logic [1:0]          buf_cnt_nxt;
    logic [DATA_LEN-1:0] head_nxt;
    logic [DATA_LEN-1:0] tail_nxt;

    // Writing at full is refused even when a read is issued in the same
    // cycle: at full the FIFO's read and write addresses coincide and its
    // bypass would hand back the new word instead of the oldest one.
    assign in_ready     = (level != FULL_LEVEL);
    assign fifo_wr_en   = in_valid & in_ready;
    assign fifo_wr_data = in_data;

    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = buf_head;
    assign pop       = out_valid & out_ready;

    // A read in flight already owns a buffer slot, so count it alongside
    // the stored words; never read an empty FIFO (keeps the bypass unused).
    assign committed  = buf_cnt + {1'b0, rd_pend} - {1'b0, pop};
    assign fifo_rd_en = (level != '0) && (committed < 2'd2);

    // Next state of the ordered two-entry output queue.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        head_nxt    = buf_head;
        tail_nxt    = buf_tail;
        buf_cnt_nxt = buf_cnt;
        case ({rd_pend, pop})
            2'b10: begin
                if (buf_cnt == 2'd0) head_nxt = fifo_rd_data;
                else                 tail_nxt = fifo_rd_data;
                buf_cnt_nxt = buf_cnt + 2'd1;
            end
            2'b01: begin
                head_nxt    = buf_tail;
                tail_nxt    = '0;
                buf_cnt_nxt = buf_cnt - 2'd1;
            end
            2'b11: begin
                // Pop and push together: count unchanged, order preserved.
                if (buf_cnt == 2'd2) begin
                    head_nxt = buf_tail;
                    tail_nxt = fifo_rd_data;
                end else begin
                    head_nxt = fifo_rd_data;
                end
            end
            default: ;
        endcase
    end

    // Occupancy, read-pending flag and output buffer registers.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            // NOTE: the buffer data registers are reset too, because out_data must read 0 when empty.
            level    <= '0;
            rd_pend  <= 1'b0;
            buf_cnt  <= 2'd0;
            buf_head <= '0;
            buf_tail <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            level    <= level + CNT_WIDTH'(fifo_wr_en) - CNT_WIDTH'(fifo_rd_en);
            rd_pend  <= fifo_rd_en;
            buf_cnt  <= buf_cnt_nxt;
            buf_head <= head_nxt;
            buf_tail <= tail_nxt;
        end
    end

`ifdef FIFO_ADAPT_STATS_EN
    // High-water mark of the registered level and saturating stall counter.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            peak_level <= '0;
            stall_cnt  <= '0;
        end else begin
            if (level > peak_level) peak_level <= level;
            if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/fifo_stream_adapter.md
# fifo_stream_adapter

Flow-control wrapper around the team's flag-less synchronous FIFO. It turns a valid/ready producer stream into safe `wr_en`/`rd_en` strobes and tracks occupancy so the FIFO never overflows or underflows. It absorbs the FIFO's fixed 1-cycle read latency into a 2-entry output buffer and presents a valid/ready stream to the next EKF datapath stage. It sits directly upstream and downstream of one FIFO instance.

## Interface
- `DATA_LEN`, default 8: payload width.
- `DEPTH`, default 8: entries in the paired FIFO; must equal the FIFO's `DEPTH`.
- `ADDR_WIDTH`, default 3: FIFO address width, with 2^ADDR_WIDTH ≥ DEPTH.
- `CNT_WIDTH`, default ADDR_WIDTH+1: occupancy counter width; must hold DEPTH.

Ports:
- `clk` in 1: clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: producer has data.
- `in_ready` out 1: adapter accepts a word this cycle.
- `in_data` in DATA_LEN: producer payload.
- `fifo_wr_en` out 1: FIFO write strobe.
- `fifo_wr_data` out DATA_LEN: FIFO write data.
- `fifo_rd_en` out 1: FIFO read strobe.
- `fifo_rd_data` in DATA_LEN: FIFO registered read data, valid the cycle after `fifo_rd_en`.
- `out_valid` out 1: output buffer non-empty.
- `out_ready` in 1: consumer accepts.
- `out_data` out DATA_LEN: head of the output buffer.
- `level` out CNT_WIDTH: words currently stored in the FIFO.

## Operation
- Write path:
  - `in_ready = (level != DEPTH)`.
  - `fifo_wr_en = in_valid & in_ready`.
  - `fifo_wr_data = in_data`, combinational.
- Never write when `level == DEPTH`, even if a read is issued the same cycle. At full, the FIFO's write and read addresses coincide and its same-address bypass would return the new word instead of the oldest.
- Read issue:
  - `pop = out_valid & out_ready`.
  - `fifo_rd_en = (level != 0) & (buf_cnt + rd_pend - pop < 2)`.
  - `rd_pend` is a register holding the previous cycle's `fifo_rd_en`.
  - Reads are never issued at `level == 0`, so the bypass path is never exercised.
- Capture: when `rd_pend == 1`, `fifo_rd_data` is pushed into the 2-entry output buffer (`buf_cnt` 0..2). When `rd_pend == 0`, `fifo_rd_data` (zero) is ignored.
- Output buffer:
  - Ordered two-register queue.
  - `out_data` is the head entry; it shows 0 when the buffer is empty.
  - A push and a pop in the same cycle keep `buf_cnt` unchanged and preserve order.
- Level update: `level <= level + fifo_wr_en - fifo_rd_en`. A simultaneous write and read leaves it unchanged.
- Invariants (bench asserts):
  - `level ≤ DEPTH`.
  - `buf_cnt + rd_pend ≤ 2`.
  - Total words held = `level + rd_pend + buf_cnt`.
- Reset (asynchronous):
  - `level`, `rd_pend`, `buf_cnt`, and buffer registers clear to 0.
  - Outputs after reset: `in_ready=1`, `out_valid=0`, `out_data=0`, `fifo_rd_en=0`, `fifo_wr_en=0` (while `in_valid=0`).
  - The adapter and its FIFO must share `sys_rst_n`. A reset mid-stream drops all buffered words, and the two blocks' pointers and counts restart together.

## Timing
- Latency: a word accepted at edge t (`in_valid & in_ready` high in cycle t-1) gives `level=1` in cycle t and `fifo_rd_en` in cycle t if the buffer has room. Its data appears on `fifo_rd_data` in t+1 and gives `out_valid` in t+2. Minimum latency from acceptance to output is 3 cycles.
- Throughput: one word per cycle in both directions when `out_ready` is held high.
- Combinational paths: `out_ready` → `fifo_rd_en`, and `in_valid` → `fifo_wr_en`. There is no path from `in_valid` to `in_ready`.
- Backpressure: with `out_ready=0`, at most 2 words leave the FIFO. Reads then stop and `level` climbs to DEPTH, at which point `in_ready` drops.

## Configuration
- `FIFO_ADAPT_STATS_EN`, when defined:
  - Adds output `peak_level` (CNT_WIDTH), the maximum `level` since reset, updated every cycle from the registered `level`. Reset value 0.
  - Adds output `stall_cnt` (16 bits), counting cycles with `in_valid & ~in_ready`. Saturates at 16'hFFFF; reset value 0.
- When undefined: neither port nor its logic exists. Core behaviour is identical either way.

## Test plan
- Single word: `in_data=8'hA5` for 1 cycle, `out_ready=1` → `out_valid` high exactly 3 cycles after acceptance, `out_data=8'hA5`, and `level` returns to 0.
- Streaming: 20 back-to-back words 0..19, `out_ready=1` → 20 words out in order with no gaps after the first, and `level` stays ≤ 1.
- Fill to full: `out_ready=0`, 12 words offered → 10 accepted (8 in FIFO plus 2 buffered), `in_ready=0` at `level=8`, `fifo_wr_en` never high at `level=8`. Then `out_ready=1` → words 0..9 out in order.
- Full with simultaneous traffic: at `level=8` with buffer full, assert `out_ready` and `in_valid` together → no write that cycle, a read is issued, and the write is accepted the next cycle. No data corruption.
- Reset mid-stream: assert `sys_rst_n=0` with `level=5` and `buf_cnt=2` → all counts 0, `out_valid=0`, `in_ready=1` immediately. After release, a new word 8'h3C is output correctly.
- Stats build: run the fill-to-full scenario with `FIFO_ADAPT_STATS_EN` defined → `peak_level=8` and `stall_cnt` equals the number of refused cycles.
